uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, data bits per frame (5..8).
REQ-002 Parameter SB_TICK, default 16, stop-bit duration in s_tick pulses (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 Parameter PAR_EN, default 0, 1 = one parity bit after the data bits.
REQ-004 Parameter PAR_ODD, default 0, 1 = odd parity, 0 = even parity; ignored when PAR_EN=0.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 s_tick  input  1  one-clk pulse at 16x baud rate, from the baud rate generator.
REQ-008 rx  input  1  asynchronous serial line; idles high.
REQ-009 rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-010 dout  output  DBIT  last received data word, LSB received first.
REQ-011 rx_done  output  1  one-clk pulse when a frame completes.
REQ-012 rx_valid  output  1  unread data present in dout.
REQ-013 frame_err  output  1  stop bit sampled low in the last frame.
REQ-014 parity_err  output  1  parity mismatch in the last frame.
REQ-015 overrun  output  1  frame completed while rx_valid was already set.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; 4-bit tick counter s_cnt (5 bits if SB_TICK>16), 3-bit bit counter n, DBIT-bit shift register.
REQ-018 IDLE: rx_s==0 -> START with s_cnt=0; s_tick is not required for this transition.
REQ-019 START: on s_tick with s_cnt==7, rx_s==0 -> DATA (s_cnt=0, n=0); rx_s==1 -> IDLE (false start, no outputs change); otherwise s_cnt++ on s_tick.
REQ-020 DATA: on s_tick with s_cnt==15, shift rx_s into the MSB (right shift) and set s_cnt=0; n==DBIT-1 -> PARITY if PAR_EN, else STOP; otherwise n++.
REQ-021 PARITY: on s_tick with s_cnt==15, capture rx_s as the parity bit -> STOP with s_cnt=0.
REQ-022 STOP: on s_tick with s_cnt==SB_TICK-1, sample rx_s -> IDLE and complete the frame.
REQ-023 Frame completion (same clock edge as the final sample) SHALL load dout, update frame_err and parity_err, assert rx_done for exactly one clk, and set rx_valid.
REQ-024 frame_err and parity_err SHALL hold until the next frame completion; parity_err=0 when PAR_EN=0.
REQ-025 Parity check: even requires an even number of ones across data+parity; odd requires an odd number.
REQ-026 A framed word with frame_err=1 SHALL still load dout.
REQ-027 rx_ack with rx_valid=1 SHALL clear rx_valid on the next edge; rx_ack coincident with completion SHALL leave rx_valid=1 (completion wins).
REQ-028 Completion while rx_valid=1 and rx_ack=0 SHALL set overrun (sticky) and overwrite dout; overrun clears on rx_ack.
REQ-029 s_tick pulses in IDLE SHALL be ignored; rx_s changes between ticks SHALL not advance the FSM except IDLE->START.

Reset
REQ-030 reset_n low SHALL force IDLE, counters 0, shift register 0, dout=0, rx_done=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, synchronizer flops=1.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; after release, reception resumes only on a new falling edge.

Structure
REQ-032 A shared package uart_pkg SHALL hold the state encoding and OVERSAMPLE=16 and MID_SAMPLE=7 constants.
REQ-033 The synchronizer SHALL be a sub-module named sync_2ff; the baud rate generator is instantiated at top level, not inside uart_rx.

Verification
REQ-034 8N1, s_tick every 10 clk, send 0xA5 -> dout=0xA5, one rx_done pulse, rx_valid=1, all error flags 0.
REQ-035 rx low for 5 ticks then high -> FSM returns to IDLE, no rx_done, dout unchanged.
REQ-036 Send 0x3C with stop bit held low -> dout=0x3C, frame_err=1; next good frame 0x11 -> frame_err=0.
REQ-037 PAR_EN=1, PAR_ODD=1, send 0x07 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0.
REQ-038 Two frames 0x12, 0x34 without rx_ack -> dout=0x34, overrun=1; then rx_ack -> rx_valid=0, overrun=0.
REQ-039 reset_n pulsed low during data bit 3 -> all outputs 0; next full frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the tick-counter width helper.
package uart_pkg;

    // Ticks per bit period and the tick index that lands mid start bit.
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // A stop phase longer than one bit period needs a 5-bit tick counter.
    function automatic int tick_cnt_width(input int sb_tick);
        return (sb_tick > OVERSAMPLE) ? 5 : 4;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input. Resets to 1
// so an idle-high serial line does not look like a start bit after reset.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first one a full cycle to resolve.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 5..8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Holds the last word with error flags and a valid/ack
// handshake including a sticky overrun indication.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter bit PAR_EN  = 1'b0,
    parameter bit PAR_ODD = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    input  logic            rx_ack,
    output logic [DBIT-1:0] dout,
    output logic            rx_done,
    output logic            rx_valid,
    output logic            frame_err,
    output logic            parity_err,
    output logic            overrun
);

    localparam int                CNT_W    = tick_cnt_width(SB_TICK);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(MID_SAMPLE);
    localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] STOP_CNT = CNT_W'(SB_TICK - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DBIT - 1);

    state_t            state, state_next;
    logic              rx_s;
    logic [CNT_W-1:0]  s_cnt;
    logic [2:0]        n;
    logic [DBIT-1:0]   shift_reg;
    logic              par_bit;

    // Sampling points within the current phase.
    logic at_mid, at_bit_end, at_stop_end, last_bit;
    assign at_mid      = s_tick && (s_cnt == MID_CNT);
    assign at_bit_end  = s_tick && (s_cnt == BIT_CNT);
    assign at_stop_end = s_tick && (s_cnt == STOP_CNT);
    assign last_bit    = (n == LAST_BIT);

    // Control strobes decoded from the FSM.
    logic cnt_clr, cnt_inc, n_clr, n_inc, shift_en, par_cap, complete;

    // Even total of ones across data+parity is correct for even parity;
    // the odd setting inverts that.
    logic parity_bad;
    assign parity_bad = (^{shift_reg, par_bit}) ^ PAR_ODD;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state logic: only the IDLE->START transition ignores s_tick.
    // NOTE: every always_comb output gets a default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (!rx_s) state_next = ST_START;
            ST_START:  if (at_mid) state_next = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (at_bit_end && last_bit)
                           state_next = PAR_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (at_bit_end) state_next = ST_STOP;
            ST_STOP:   if (at_stop_end) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output decode: per-state counter, shift and completion strobes.
    always_comb begin
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        n_clr    = 1'b0;
        n_inc    = 1'b0;
        shift_en = 1'b0;
        par_cap  = 1'b0;
        complete = 1'b0;
        case (state)
            ST_IDLE: cnt_clr = !rx_s;
            ST_START: begin
                if (at_mid) begin
                    cnt_clr = 1'b1;
                    n_clr   = !rx_s;
                end else begin
                    cnt_inc = s_tick;
                end
            end
            ST_DATA: begin
                if (at_bit_end) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    n_inc    = !last_bit;
                end else begin
                    cnt_inc = s_tick;
                end
            end
            ST_PARITY: begin
                if (at_bit_end) begin
                    cnt_clr = 1'b1;
                    par_cap = 1'b1;
                end else begin
                    cnt_inc = s_tick;
                end
            end
            ST_STOP: begin
                if (at_stop_end) begin
                    cnt_clr  = 1'b1;
                    complete = 1'b1;
                end else begin
                    cnt_inc = s_tick;
                end
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    // Datapath: tick counter, bit counter, shift register, parity bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_cnt     <= '0;
            n         <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
        end else begin
            if (cnt_clr)      s_cnt <= '0;
            else if (cnt_inc) s_cnt <= s_cnt + CNT_W'(1);

            if (n_clr)      n <= '0;
            else if (n_inc) n <= n + 3'd1;

            if (shift_en) shift_reg <= {rx_s, shift_reg[DBIT-1:1]};
            if (par_cap)  par_bit   <= rx_s;
        end
    end

    // Frame completion and the consumer handshake; completion beats rx_ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout       <= '0;
            rx_done    <= 1'b0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_done <= complete;
            if (complete) begin
                dout       <= shift_reg;
                frame_err  <= !rx_s;
                parity_err <= PAR_EN & parity_bad;
            end

            if (complete)    rx_valid <= 1'b1;
            else if (rx_ack) rx_valid <= 1'b0;

            if (complete && rx_valid && !rx_ack) overrun <= 1'b1;
            else if (rx_ack)                     overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Channel 0 is an 8N1 receiver, channel 1
// is 8 data bits, odd parity, two stop bits. Frames are bit-banged on rx and
// compared against a word-level model of the expected receiver outputs.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_tick = 1'b0;
    logic       rx_l       [2];
    logic       rx_ack_l   [2];
    logic       rx_done_l  [2];
    logic       rx_valid_l [2];
    logic       frame_err_l[2];
    logic       parity_err_l[2];
    logic       overrun_l  [2];
    logic [7:0] dout_l     [2];

    int n_vec = 0;
    int n_err = 0;

    int tick_div   = 0;
    int tick_count = 0;
    int done_cnt [2] = '{0, 0};
    int sb_of    [2] = '{16, 32};

    // Reference model: what each receiver should currently present.
    logic [7:0] m_dout [2];
    bit         m_valid[2];
    bit         m_ferr [2];
    bit         m_perr [2];
    bit         m_ovr  [2];

    always #5 clk = ~clk;

    // s_tick: one clk wide, every 10 clk, changed on the falling edge.
    always @(negedge clk) begin
        if (tick_div == 9) begin
            tick_div   <= 0;
            s_tick     <= 1'b1;
            tick_count <= tick_count + 1;
        end else begin
            tick_div <= tick_div + 1;
            s_tick   <= 1'b0;
        end
    end

    // Count rx_done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++)
            if (rx_done_l[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end

    uart_rx dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_tick     (s_tick),
        .rx         (rx_l[0]),
        .rx_ack     (rx_ack_l[0]),
        .dout       (dout_l[0]),
        .rx_done    (rx_done_l[0]),
        .rx_valid   (rx_valid_l[0]),
        .frame_err  (frame_err_l[0]),
        .parity_err (parity_err_l[0]),
        .overrun    (overrun_l[0])
    );

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (32),
        .PAR_EN  (1'b1),
        .PAR_ODD (1'b1)
    ) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_tick     (s_tick),
        .rx         (rx_l[1]),
        .rx_ack     (rx_ack_l[1]),
        .dout       (dout_l[1]),
        .rx_done    (rx_done_l[1]),
        .rx_valid   (rx_valid_l[1]),
        .frame_err  (frame_err_l[1]),
        .parity_err (parity_err_l[1]),
        .overrun    (overrun_l[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = tick_count + n;
        while (tick_count < target) @(negedge clk);
    endtask

    task automatic drive_bit(input int ch, input logic v, input int n);
        rx_l[ch] = v;
        wait_ticks(n);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_dout[i]  = 8'h00;
            m_valid[i] = 1'b0;
            m_ferr[i]  = 1'b0;
            m_perr[i]  = 1'b0;
            m_ovr[i]   = 1'b0;
        end
    endtask

    task automatic check_all(input int ch, input string what);
        check($sformatf("%s ch%0d dout", what, ch),       dout_l[ch],       m_dout[ch]);
        check($sformatf("%s ch%0d rx_valid", what, ch),   rx_valid_l[ch],   m_valid[ch]);
        check($sformatf("%s ch%0d frame_err", what, ch),  frame_err_l[ch],  m_ferr[ch]);
        check($sformatf("%s ch%0d parity_err", what, ch), parity_err_l[ch], m_perr[ch]);
        check($sformatf("%s ch%0d overrun", what, ch),    overrun_l[ch],    m_ovr[ch]);
    endtask

    // Send one frame. A bad stop bit is held low past the stop sample point,
    // then released so the line is idle again before the next frame.
    task automatic send_frame(input int ch, input logic [7:0] data, input bit stop_ok,
                              input logic pbit, input string what);
        int d0;
        d0 = done_cnt[ch];
        drive_bit(ch, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(ch, data[i], 16);
        if (ch == 1) drive_bit(ch, pbit, 16);
        if (stop_ok) begin
            drive_bit(ch, 1'b1, sb_of[ch]);
        end else begin
            drive_bit(ch, 1'b0, sb_of[ch] - 6);
            drive_bit(ch, 1'b1, 6);
        end
        drive_bit(ch, 1'b1, 12);

        if (m_valid[ch]) m_ovr[ch] = 1'b1;
        m_valid[ch] = 1'b1;
        m_dout[ch]  = data;
        m_ferr[ch]  = !stop_ok;
        // Odd parity: the ones across data and parity must total an odd count.
        m_perr[ch]  = (ch == 1) ? ((($countones(data) + int'(pbit)) % 2) == 0) : 1'b0;

        check($sformatf("%s ch%0d rx_done pulses", what, ch), done_cnt[ch] - d0, 1);
        check_all(ch, what);
    endtask

    task automatic ack(input int ch);
        @(negedge clk);
        rx_ack_l[ch] = 1'b1;
        @(negedge clk);
        rx_ack_l[ch] = 1'b0;
        m_valid[ch] = 1'b0;
        m_ovr[ch]   = 1'b0;
        @(negedge clk);
        check($sformatf("ack ch%0d rx_valid", ch), rx_valid_l[ch], 1'b0);
        check($sformatf("ack ch%0d overrun", ch),  overrun_l[ch],  1'b0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached before the run completed");
        $fatal(1, "watchdog");
    end

    initial begin
        int         d0;
        logic [7:0] d;

        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rx_l[i]     = 1'b1;
            rx_ack_l[i] = 1'b0;
        end
        model_reset();
        repeat (5) @(negedge clk);
        check_all(0, "reset");
        check_all(1, "reset");
        reset_n = 1'b1;
        wait_ticks(4);

        // Basic 8N1 frame.
        send_frame(0, 8'hA5, 1'b1, 1'b0, "a5");
        ack(0);

        // False start: low for 5 ticks only.
        d0 = done_cnt[0];
        drive_bit(0, 1'b0, 5);
        drive_bit(0, 1'b1, 20);
        check("false start rx_done pulses", done_cnt[0] - d0, 0);
        check_all(0, "false start");

        // Framing error, then a clean frame clears it.
        send_frame(0, 8'h3C, 1'b0, 1'b0, "bad stop");
        ack(0);
        send_frame(0, 8'h11, 1'b1, 1'b0, "good after bad");
        ack(0);

        // Overrun: two frames without ack.
        send_frame(0, 8'h12, 1'b1, 1'b0, "ovr first");
        send_frame(0, 8'h34, 1'b1, 1'b0, "ovr second");
        ack(0);

        // Odd parity on 0x07: parity bit 1 is wrong, 0 is right.
        send_frame(1, 8'h07, 1'b1, 1'b1, "par bad");
        ack(1);
        send_frame(1, 8'h07, 1'b1, 1'b0, "par good");
        ack(1);

        // Randomized frames on both channels.
        for (int k = 0; k < 6; k++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if ($urandom_range(0, 1) == 1) ack(ch);
                d = 8'($urandom);
                send_frame(ch, d, $urandom_range(0, 3) != 0, 1'($urandom),
                           $sformatf("rand%0d", k));
            end
        end

        // Reset during data bit 3 discards the frame.
        drive_bit(0, 1'b0, 16);
        d = 8'h5A;
        for (int i = 0; i < 3; i++) drive_bit(0, d[i], 16);
        drive_bit(0, d[3], 8);
        reset_n  = 1'b0;
        rx_l[0]  = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("mid-frame reset ch0 rx_done", rx_done_l[0], 1'b0);
        check_all(0, "mid-frame reset");
        check_all(1, "mid-frame reset");
        reset_n = 1'b1;
        wait_ticks(4);
        send_frame(0, 8'h5A, 1'b1, 1'b0, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
